// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of one synchronous memory.
// Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> CAPTURE -> ACK.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    ACK
  } state_t;

  localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    wait_cnt;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          lat_we;
  logic          lat_port;
  logic          last_grant;
  logic          any_req;
  logic          pick;

  assign any_req  = p0_req | p1_req;
  assign grant_id = last_grant;

  // Ties go to the port that did not win last time.
  always_comb begin
    pick = last_grant;
    unique case (1'b1)
      p0_req && p1_req:  pick = ~last_grant;
      p0_req && !p1_req: pick = 1'b0;
      !p0_req && p1_req: pick = 1'b1;
      default:           pick = last_grant;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (wait_cnt == LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    if (state == ACCESS) begin
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      mem_wren  = lat_we && (wait_cnt == 3'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
      lat_port   <= 1'b1;
      last_grant <= 1'b1;
      wait_cnt   <= 3'd0;
    end else begin
      if (state == IDLE) begin
        wait_cnt <= 3'd0;
        if (any_req) begin
          lat_port   <= pick;
          last_grant <= pick;
          lat_addr   <= pick ? p1_addr  : p0_addr;
          lat_wdata  <= pick ? p1_wdata : p0_wdata;
          lat_we     <= pick ? p1_we    : p0_we;
        end
      end else if (state == ACCESS) begin
        wait_cnt <= wait_cnt + 3'd1;
      end
    end
  end

  // Ack is registered so it is high for exactly the ACK cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_ack   <= 1'b0;
      p1_ack   <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      p0_ack <= (state == CAPTURE) && !lat_port;
      p1_ack <= (state == CAPTURE) && lat_port;
      if (state == CAPTURE && !lat_we) begin
        if (lat_port) p1_rdata <= mem_rdata;
        else          p0_rdata <= mem_rdata;
      end
    end
  end

endmodule
